// File: rtl/data_memory_responder.sv
// LC3 data-memory responder: services D_macc read/write requests after LATENCY wait states.
// Define DMEM_ADDR_CHECK_EN to drop out-of-range accesses and flag them on addr_err.
module data_memory_responder #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              D_macc,
  input  logic              Data_rd,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  output logic              busy,
  output logic              addr_err,
  output logic [1:0]        state_o
);
  // Handshake: a request is taken on any edge where D_macc=1 and the block is in IDLE or DONE;
  // rd/addr/din are sampled on that same edge, and complete_data marks the single result cycle.
  localparam int         IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_L = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              rd_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [IDX_W-1:0]  idx_sel, idx_q;
  logic              sel_ok, q_ok;
  logic              commit_wr;
  logic              unused_addr;

`ifdef DMEM_ADDR_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  assign sel_ok = ({1'b0, addr_sel} < DEPTH_L);
  assign q_ok   = ({1'b0, addr_q} < DEPTH_L);
`else
  assign sel_ok = 1'b1;
  assign q_ok   = 1'b1;
`endif

  // The read is evaluated on the edge entering DONE: from the holding regs after a wait,
  // or straight from the bus when LATENCY=0 takes IDLE/DONE directly to DONE.
  assign rd_sel      = (state_q == S_WAIT) ? rd_q : Data_rd;
  assign addr_sel    = (state_q == S_WAIT) ? addr_q : Data_addr;
  assign idx_sel     = addr_sel[IDX_W-1:0];
  assign idx_q       = addr_q[IDX_W-1:0];
  assign unused_addr = ^{addr_sel, addr_q};
  assign commit_wr   = (state_q == S_DONE) && !rd_q && q_ok && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (D_macc) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_L;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A write retiring on the same edge as a LATENCY=0 read of the same word is forwarded.
  always_comb begin
    dout_d = dout_q;
    if ((state_d == S_DONE) && rd_sel) begin
      if (!sel_ok)                              dout_d = '0;
      else if (commit_wr && (idx_q == idx_sel)) dout_d = din_q;
      else                                      dout_d = mem[idx_sel];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      rd_q   <= Data_rd;
      addr_q <= Data_addr;
      din_q  <= Data_din;
    end
  end

  always_ff @(posedge clock) begin
    if (commit_wr) mem[idx_q] <= din_q;
  end

  assign Data_dout     = dout_q;
  assign complete_data = (state_q == S_DONE);
  assign busy          = (state_q == S_WAIT);
  assign addr_err      = (state_q == S_DONE) && !q_ok;
  assign state_o       = state_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: LATENCY=2 and LATENCY=0 instances share one request bus
// and are checked every cycle against a transaction-level model, plus directed scenarios.
module tb_data_memory_responder;
  localparam int DEPTH = 1024;
`ifdef DMEM_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        D_macc = 1'b0;
  logic        Data_rd = 1'b0;
  logic [15:0] Data_addr = '0;
  logic [15:0] Data_din = '0;
  logic [15:0] dout2, dout0;
  logic        cd2, cd0, busy2, busy0, err2, err0;
  logic [1:0]  st2, st0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  data_memory_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
    .clock(clock), .reset(reset), .D_macc(D_macc), .Data_rd(Data_rd),
    .Data_addr(Data_addr), .Data_din(Data_din), .Data_dout(dout2),
    .complete_data(cd2), .busy(busy2), .addr_err(err2), .state_o(st2)
  );

  data_memory_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
    .clock(clock), .reset(reset), .D_macc(D_macc), .Data_rd(Data_rd),
    .Data_addr(Data_addr), .Data_din(Data_din), .Data_dout(dout0),
    .complete_data(cd0), .busy(busy0), .addr_err(err0), .state_o(st0)
  );

  // Model: per instance, cycles remaining until the result cycle (-1 = nothing in flight).
  int          lat [2] = '{2, 0};
  int          rem [2] = '{-1, -1};
  logic        m_rd [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_din [2];
  logic [15:0] m_dout [2] = '{16'h0, 16'h0};
  logic        m_known [2] = '{1'b1, 1'b1};
  logic [15:0] ref_mem [int];
  logic [15:0] exp_q [$];

  function automatic bit addr_ok(input logic [15:0] a);
    return !CHECK_EN || (int'(a) < DEPTH);
  endfunction

  function automatic int mkey(input int k, input logic [15:0] a);
    return k * 65536 + (int'(a) % DEPTH);
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        rem[k] = -1; m_dout[k] = '0; m_known[k] = 1'b1;
      end else begin
        if (rem[k] == 0 && !m_rd[k] && addr_ok(m_addr[k])) ref_mem[mkey(k, m_addr[k])] = m_din[k];
        if (D_macc && rem[k] <= 0) begin
          m_rd[k] = Data_rd; m_addr[k] = Data_addr; m_din[k] = Data_din; rem[k] = lat[k];
        end else if (rem[k] > 0) begin
          rem[k] = rem[k] - 1;
        end else begin
          rem[k] = -1;
        end
        if (rem[k] == 0 && m_rd[k]) begin
          if (!addr_ok(m_addr[k])) begin
            m_dout[k] = '0; m_known[k] = 1'b1;
          end else if (ref_mem.exists(mkey(k, m_addr[k]))) begin
            m_dout[k] = ref_mem[mkey(k, m_addr[k])]; m_known[k] = 1'b1;
          end else begin
            m_known[k] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("l2_complete", 16'(cd2), 16'(rem[0] == 0));
    chk("l2_busy", 16'(busy2), 16'(rem[0] > 0));
    chk("l2_addr_err", 16'(err2), 16'(rem[0] == 0 && !addr_ok(m_addr[0])));
    if (m_known[0]) chk("l2_dout", dout2, m_dout[0]);
    chk("l0_complete", 16'(cd0), 16'(rem[1] == 0));
    chk("l0_busy", 16'(busy0), 16'(rem[1] > 0));
    chk("l0_addr_err", 16'(err0), 16'(rem[1] == 0 && !addr_ok(m_addr[1])));
    if (m_known[1]) chk("l0_dout", dout0, m_dout[1]);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_model();
  endtask

  task automatic req(input logic rd, input logic [15:0] a, input logic [15:0] d);
    D_macc = 1'b1; Data_rd = rd; Data_addr = a; Data_din = d;
    cycle();
    D_macc = 1'b0;
  endtask

  // n counts cycles from the request cycle (n=1) to the cycle showing complete_data.
  task automatic wait_complete(input int k, output int n);
    n = 1;
    while (!((k == 0) ? cd2 : cd0) && n < 20) begin
      cycle();
      n++;
    end
  endtask

  logic [15:0] pool [8] = '{16'h0000, 16'h0005, 16'h0010, 16'h0020,
                            16'h03FF, 16'h0400, 16'h0405, 16'h07FF};

  initial begin
    int n;
    int gap;
    int sel;
    reset = 1'b1;
    cycle(); cycle(); cycle();
    chk("rst_dout2", dout2, 16'h0000);
    chk("rst_dout0", dout0, 16'h0000);
    chk("rst_flags", 16'({cd2, busy2, err2, cd0, busy0, err0}), 16'h0000);
    reset = 1'b0;
    cycle();

    // Write then read at LATENCY=2.
    req(1'b0, 16'h0010, 16'h1234);
    wait_complete(0, n);
    chk("t1_wr_latency", 16'(n), 16'd3);
    cycle();
    exp_q.push_back(16'h1234);
    req(1'b1, 16'h0010, 16'h0000);
    wait_complete(0, n);
    chk("t1_rd_latency", 16'(n), 16'd3);
    chk("t1_rd_data", dout2, exp_q.pop_front());
    cycle();

    // LATENCY=0 read after reset of a word written before the reset.
    req(1'b0, 16'h0005, 16'h5A5A);
    wait_complete(0, n);
    cycle();
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    req(1'b1, 16'h0005, 16'h0000);
    wait_complete(1, n);
    chk("t2_latency", 16'(n), 16'd1);
    chk("t2_rd_data", dout0, 16'h5A5A);
    chk("t2_busy", 16'(busy0), 16'h0000);
    wait_complete(0, n);
    cycle();

    // D_macc held high: write then read the same word back to back.
    D_macc = 1'b1; Data_rd = 1'b0; Data_addr = 16'h03FF; Data_din = 16'hBEEF;
    cycle();
    Data_rd = 1'b1; Data_din = 16'h0000;
    wait_complete(0, n);
    gap = 0;
    do begin
      cycle();
      gap++;
    end while (!cd2 && gap < 20);
    D_macc = 1'b0;
    chk("t3_gap", 16'(gap), 16'd3);
    chk("t3_rd_data", dout2, 16'hBEEF);
    cycle(); cycle(); cycle(); cycle();

    // Reset during the wait of a write aborts it.
    req(1'b0, 16'h0020, 16'h1111);
    wait_complete(0, n);
    cycle();
    req(1'b0, 16'h0020, 16'hAAAA);
    reset = 1'b1;
    cycle();
    chk("t4_no_cd_rst", 16'(cd2), 16'h0000);
    cycle();
    reset = 1'b0;
    cycle();
    chk("t4_idle", 16'({cd2, busy2}), 16'h0000);
    req(1'b1, 16'h0020, 16'h0000);
    wait_complete(0, n);
    chk("t4_old_data", dout2, 16'h1111);
    cycle();

    // Out-of-range address: dropped and flagged, or aliased onto word 0.
    req(1'b0, 16'h0000, 16'h0F0F);
    wait_complete(0, n);
    cycle();
    req(1'b0, 16'h0400, 16'h5555);
    wait_complete(0, n);
    chk("t5_wr_err", 16'(err2), 16'(CHECK_EN));
    cycle();
    req(1'b1, 16'h0400, 16'h0000);
    wait_complete(0, n);
    chk("t5_rd_err", 16'(err2), 16'(CHECK_EN));
    chk("t5_rd_data", dout2, CHECK_EN ? 16'h0000 : 16'h5555);
    cycle();
    req(1'b1, 16'h0000, 16'h0000);
    wait_complete(0, n);
    chk("t5_word0", dout2, CHECK_EN ? 16'h0F0F : 16'h5555);
    chk("t5_word0_err", 16'(err2), 16'h0000);
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 63) == 0);
      D_macc  = ($urandom_range(0, 2) != 0);
      Data_rd = 1'($urandom_range(0, 1));
      sel     = $urandom_range(0, 8);
      Data_addr = (sel == 8) ? 16'($urandom) : pool[sel];
      Data_din  = 16'($urandom);
      cycle();
    end
    reset = 1'b0;
    D_macc = 1'b0;
    cycle(); cycle(); cycle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
